// File: rtl/midi_pkg.sv
// midi_pkg: shared constants, slot/message types and message decode for the voice allocator
package midi_pkg;
   localparam int         NUM_VOICES  = 5;
   localparam logic [3:0] ST_NOTE_ON  = 4'h9;
   localparam logic [3:0] ST_NOTE_OFF = 4'h8;
   localparam logic [3:0] ST_CC       = 4'hB;
   localparam logic [7:0] CC_ALL_OFF  = 8'h7B;

   typedef struct packed {
      logic [7:0] note;
      logic [7:0] vel;
      logic       on;
      logic [1:0] age;
   } voice_slot_t;

   typedef enum logic [1:0] {K_NONE, K_ON, K_OFF, K_ALLOFF} msg_kind_t;

   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_UPDATE} state_t;

   function automatic msg_kind_t decode_msg(input logic [7:0] status, input logic [7:0] d1,
                                            input logic [7:0] d2, input logic chan_ok);
      return !chan_ok                                           ? K_NONE   :
             (status[7:4] == ST_NOTE_ON && d2 != 8'h00)         ? K_ON     :
             (status[7:4] == ST_NOTE_OFF || status[7:4] == ST_NOTE_ON) ? K_OFF :
             (status[7:4] == ST_CC && d1 == CC_ALL_OFF)         ? K_ALLOFF : K_NONE;
   endfunction
endpackage

// File: rtl/midi_voice_allocator_search.sv
// voice_slot_search: combinational match / lowest-free / oldest-steal lookup over the slot table
module voice_slot_search
   import midi_pkg::*;
#(
   parameter int SLOTS = NUM_VOICES,
   parameter int IW    = $clog2(SLOTS)
) (
   input  voice_slot_t   slots_in [SLOTS],
   input  logic [7:0]    note_in,
   output logic          match_hit_out,
   output logic [IW-1:0] match_idx_out,
   output logic          free_hit_out,
   output logic [IW-1:0] free_idx_out,
   output logic [IW-1:0] steal_idx_out
);
   logic [1:0] best_age;

   // Descending scan leaves the lowest hit; ascending strict-greater keeps the lowest index on age ties
   always_comb begin
      match_hit_out = 1'b0;
      match_idx_out = '0;
      free_hit_out  = 1'b0;
      free_idx_out  = '0;
      steal_idx_out = IW'(1);
      best_age      = slots_in[1].age;
      for (int i = SLOTS - 1; i >= 1; i--) begin
         if (slots_in[i].on && slots_in[i].note == note_in) begin
            match_hit_out = 1'b1;
            match_idx_out = IW'(i);
         end
         if (!slots_in[i].on) begin
            free_hit_out = 1'b1;
            free_idx_out = IW'(i);
         end
      end
      for (int i = 2; i < SLOTS; i++) begin
         if (slots_in[i].age > best_age) begin
            best_age      = slots_in[i].age;
            steal_idx_out = IW'(i);
         end
      end
   end
endmodule

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: MIDI note policy engine feeding the waveform combiner's burst interface
module midi_voice_allocator #(
   parameter int NUM_VOICES = midi_pkg::NUM_VOICES,
   parameter int CHANNEL    = 0,
   parameter int OMNI       = 0,
   parameter int CHANGE_GAP = 64
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  msg_valid_in,
   output logic                  msg_ready_out,
   input  logic [7:0]            status_in,
   input  logic [7:0]            data1_in,
   input  logic [7:0]            data2_in,
   output logic [15:0]           midi_burst_data_out [NUM_VOICES],
   output logic [NUM_VOICES-1:0] on_array_out,
   output logic                  midi_burst_change_out,
   output logic [2:0]            active_count_out
);
   import midi_pkg::*;

   localparam int IW = $clog2(NUM_VOICES);
   localparam int GW = (CHANGE_GAP > 2) ? $clog2(CHANGE_GAP) : 1;

   state_t        state_q, state_d;
   msg_kind_t     kind_q, kind_d;
   logic [7:0]    status_q, status_d, note_q, note_d, vel_q, vel_d;
   logic          match_hit_q, match_hit_d, free_hit_q, free_hit_d;
   logic [IW-1:0] match_idx_q, match_idx_d, free_idx_q, free_idx_d, steal_idx_q, steal_idx_d;
   voice_slot_t   slots_q [NUM_VOICES];
   voice_slot_t   slots_d [NUM_VOICES];
   logic          pending_q, pending_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          s_match_hit, s_free_hit;
   logic [IW-1:0] s_match_idx, s_free_idx, s_steal_idx, tgt;
   logic          strobe, changed;

   voice_slot_search #(.SLOTS(NUM_VOICES), .IW(IW)) u_search (
      .slots_in      (slots_q),
      .note_in       (note_q),
      .match_hit_out (s_match_hit),
      .match_idx_out (s_match_idx),
      .free_hit_out  (s_free_hit),
      .free_idx_out  (s_free_idx),
      .steal_idx_out (s_steal_idx)
   );

   // IDLE latches, SEARCH registers lookup results, UPDATE writes the table; the gap counter runs freely
   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      status_d    = status_q;
      note_d      = note_q;
      vel_d       = vel_q;
      match_hit_d = match_hit_q;
      match_idx_d = match_idx_q;
      free_hit_d  = free_hit_q;
      free_idx_d  = free_idx_q;
      steal_idx_d = steal_idx_q;
      slots_d     = slots_q;
      changed     = 1'b0;
      tgt         = free_hit_q ? free_idx_q : steal_idx_q;
      strobe      = pending_q && gap_q == '0 && state_q == S_IDLE;
      pending_d   = strobe ? 1'b0 : pending_q;
      gap_d       = strobe ? GW'(CHANGE_GAP - 1) : (gap_q != '0 ? gap_q - 1'b1 : gap_q);
      case (state_q)
         S_IDLE: begin
            if (msg_valid_in) begin
               status_d = status_in;
               note_d   = data1_in;
               vel_d    = data2_in;
               state_d  = S_SEARCH;
            end
         end
         S_SEARCH: begin
            kind_d      = decode_msg(status_q, note_q, vel_q, OMNI != 0 || status_q[3:0] == 4'(CHANNEL));
            match_hit_d = s_match_hit;
            match_idx_d = s_match_idx;
            free_hit_d  = s_free_hit;
            free_idx_d  = s_free_idx;
            steal_idx_d = s_steal_idx;
            state_d     = S_UPDATE;
         end
         S_UPDATE: begin
            state_d = S_IDLE;
            if (kind_q == K_ON && match_hit_q) begin
               slots_d[match_idx_q].vel = vel_q;
               changed = 1'b1;
            end else if (kind_q == K_ON) begin
               for (int i = 1; i < NUM_VOICES; i++)
                  if (slots_q[i].on && slots_q[i].age != 2'd3 && IW'(i) != tgt)
                     slots_d[i].age = slots_q[i].age + 2'd1;
               slots_d[tgt] = '{note: note_q, vel: vel_q, on: 1'b1, age: 2'd0};
               changed = 1'b1;
            end else if (kind_q == K_OFF && match_hit_q) begin
               slots_d[match_idx_q] = '0;
               changed = 1'b1;
            end else if (kind_q == K_ALLOFF) begin
               for (int i = 0; i < NUM_VOICES; i++)
                  slots_d[i] = '0;
               changed = |on_array_out;
            end
            if (changed) pending_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state, table, pending flag and gap counter; reset drops any in-flight message
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= S_IDLE;
         slots_q   <= '{default: '0};
         pending_q <= 1'b0;
         gap_q     <= '0;
      end else begin
         state_q   <= state_d;
         slots_q   <= slots_d;
         pending_q <= pending_d;
         gap_q     <= gap_d;
      end
   end

   // Message latch and lookup results are only consumed after being written, so they need no reset
   always_ff @(posedge clk_in) begin
      kind_q      <= kind_d;
      status_q    <= status_d;
      note_q      <= note_d;
      vel_q       <= vel_d;
      match_hit_q <= match_hit_d;
      match_idx_q <= match_idx_d;
      free_hit_q  <= free_hit_d;
      free_idx_q  <= free_idx_d;
      steal_idx_q <= steal_idx_d;
   end

   // Burst words, on flags and active count are straight views of the registered table
   always_comb begin
      active_count_out = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         midi_burst_data_out[i] = {slots_q[i].note, slots_q[i].vel};
         on_array_out[i]        = slots_q[i].on;
         active_count_out       = active_count_out + 3'(slots_q[i].on);
      end
   end

   assign msg_ready_out         = state_q == S_IDLE;
   assign midi_burst_change_out = strobe;
endmodule

// File: doc/midi_voice_allocator.md
# midi_voice_allocator

- Receives parsed MIDI channel messages and maintains the 5-slot active-voice table.
- Drives that table into the waveform combiner's burst interface: per-slot `{note, velocity}` words, an `on_array`, and a one-cycle `midi_burst_change_out` strobe.
- Owns all policy: note-on/off, re-trigger, voice stealing, and rate-limiting of change strobes to the combiner's processing time.
- Sits between the MIDI byte parser and the waveform combiner.

## Interface

Parameters:
- `NUM_VOICES`, 5: slot count. Slot 0 is reserved and never allocated; slots 1..4 are usable.
- `CHANNEL`, 0: MIDI channel accepted (0–15).
- `OMNI`, 0: when 1, the channel filter is disabled.
- `CHANGE_GAP`, 64: minimum clock cycles between successive `midi_burst_change_out` pulses.

Ports:
- `clk_in` input, 1: system clock. Single clock domain.
- `rst_in` input, 1: synchronous, active-high reset.
- `msg_valid_in` input, 1: a complete 3-byte message is presented.
- `msg_ready_out` output, 1: allocator can accept a message. Reset value 1.
- `status_in` input, 8: MIDI status byte.
- `data1_in` input, 8: note number, or controller number.
- `data2_in` input, 8: velocity, or controller value.
- `midi_burst_data_out[NUM_VOICES]` output, 16 each: `{note[15:8], velocity[7:0]}`. Reset value 0.
- `on_array_out` output, NUM_VOICES: slot active flags. Bit 0 is always 0. Reset value 0.
- `midi_burst_change_out` output, 1: one-cycle strobe meaning the table has changed and is stable. Reset value 0.
- `active_count_out` output, 3: popcount of `on_array_out`. Reset value 0.

## Operation

Message decode (applied only after the channel check passes):
- Note-on: `status[7:4]=0x9` with `data2≠0`.
- Note-off: `status[7:4]=0x8`, or `0x9` with `data2=0`.
- All-notes-off: `status[7:4]=0xB` with `data1=0x7B`.
- Every other message is accepted and discarded with no effect.

Per-slot state:
- note, velocity, on bit, and a 2-bit age counter.

Note-on:
- If the note is already active in slot s: velocity[s] is overwritten; age is unchanged.
- Else, if a free slot exists: take the lowest-index free slot in 1..4.
- Else: steal the active slot with the highest age; ties go to the lowest index.
- On a new allocation into slot s: age[s]=0, and every other active slot's age increments, saturating at 3.

Note-off:
- The matching active slot is cleared: data=0, on=0, age=0.
- If no slot matches: no effect and no change is flagged.

All-notes-off:
- Clears every slot.
- Flags a change only if at least one slot was active.

State machine:
- **IDLE**: `msg_ready_out`=1. On `msg_valid_in && msg_ready_out`, latch the message and go to SEARCH.
- **SEARCH**: register match index, free index, steal index and message kind. Go to UPDATE.
- **UPDATE**: write the table. Set `pending` if the table changed. Go to IDLE.

Change strobe:
- A separate gap counter `gap_cnt` runs independently of the state machine.
- A pulse is issued when `pending && gap_cnt==0 && state==IDLE`.
- On pulse: `gap_cnt` is loaded with CHANGE_GAP−1 and `pending` is cleared.
- Multiple changes inside one gap coalesce into a single pulse carrying the final table.

## Timing

- Message accepted at cycle T: SEARCH at T+1, UPDATE at T+2.
- Table outputs and `active_count_out` reflect the message from T+3.
- `msg_ready_out` is low at T+1 and T+2, and high again at T+3.
- `midi_burst_change_out` fires at T+3 when `gap_cnt` is 0. Otherwise it fires on the first cycle `gap_cnt` reaches 0.
- Table outputs only change in UPDATE. They never change in the same cycle as a strobe.
- Back-to-back messages: throughput is one message per 3 cycles.
- `msg_valid_in` while `msg_ready_out`=0 is ignored. The parser holds the message until ready.
- Reset mid-operation:
  - All outputs return to their reset values the next cycle.
  - `pending`, `gap_cnt` and all ages are cleared.
  - An in-flight message is dropped.
- An empty table (all off) still produces a strobe, so the combiner returns to IDLE.

## Structure

Shared package `midi_pkg`:
- Constants: `NUM_VOICES`, `ST_NOTE_ON`=0x9, `ST_NOTE_OFF`=0x8, `ST_CC`=0xB, `CC_ALL_OFF`=0x7B.
- Typedef `voice_slot_t` `{note[7:0], vel[7:0], on, age[1:0]}`.
- Enum `msg_kind_t` `{K_NONE, K_ON, K_OFF, K_ALLOFF}`.

Sub-module `voice_slot_search`:
- Purely combinational.
- Inputs: the slot table and the note.
- Outputs: `match_hit`/`match_idx`, `free_hit`/`free_idx`, `steal_idx`.

## Test plan

- **Single note**: reset, then send `0x90 0x3C 0x64`. Required response:
  - Slot 1 = 0x3C64 and `on_array_out`=5'b00010, stable from T+3.
  - One strobe at T+3.
  - `active_count_out`=1.
- **Fill and steal**: note-ons 60, 62, 64, 65, each spaced >CHANGE_GAP, then note-on 67 vel 0x40. Required response:
  - Slot 1 (oldest, note 60) becomes 0x4340.
  - Slots 2–4 are unchanged.
  - `on_array_out`=5'b11110.
- **Retrigger and stray off**: note-on 60 vel 0x20, then note-on 60 vel 0x7F, then note-off 61. Required response:
  - Slot 1 = 0x3C7F.
  - Exactly 2 strobes; the stray off produces no strobe.
- **Coalescing**: 4 note-ons back-to-back (3 cycles apart) with CHANGE_GAP=64. Required response:
  - First strobe carries 1 voice.
  - Exactly one more strobe, 64 cycles later, with `on_array_out`=5'b11110.
- **Filter, all-off, and reset**: steps and required responses:
  - `0x91` note-on with CHANNEL=0, OMNI=0 is ignored (no strobe).
  - `0xB0 0x7B 0x00` with 2 voices active gives all slots 0 and one strobe.
  - `rst_in` asserted during SEARCH clears all outputs the next cycle, with `msg_ready_out`=1 and no strobe afterwards.
